mult_div_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage, directly downstream of the register file.
- Consumes the two register-file read operands (rs, rt) for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Holds the architectural HI/LO registers.
- Asserts busy so the hazard unit stalls any instruction that reads HI/LO before the result is ready.

---
 rtl/mult_div_unit.sv | 172 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide.
// Optional MULDIV_DIVZERO_TRAP_EN: flag divide-by-zero on divZero, keep HI/LO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIVZERO_TRAP_EN
  ,
  output logic             divZero
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;

  logic             accept;
  logic             mt_op;
  logic             sgn;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   madd;
  logic [WIDTH:0]   shf;
  logic             q_bit;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] rem_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign busy   = (state != IDLE);
  assign accept = start && !flush && !op[2];
  assign mt_op  = start && !flush && op[2] && !op[1];
  assign sgn    = !op[0];

  always_comb begin
    a_abs = srcA;
    b_abs = srcB;
    if (sgn && srcA[WIDTH-1]) a_abs = -srcA;
    if (sgn && srcB[WIDTH-1]) b_abs = -srcB;
  end

  // One datapath step; divide keeps the remainder in acc_hi.
  always_comb begin
    madd    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shf     = {acc_hi, acc_lo[WIDTH-1]};
    q_bit   = (shf >= {1'b0, opnd});
    trial   = shf[WIDTH-1:0] - opnd;
    rem_nxt = q_bit ? trial : shf[WIDTH-1:0];
  end

  always_comb begin
    prod   = {acc_hi, acc_lo};
    res_hi = acc_hi;
    res_lo = acc_lo;
    if (is_div) begin
      if (neg_q) res_lo = -acc_lo;
      if (neg_r) res_hi = -acc_hi;
    end else if (neg_q) begin
      prod = -prod;
      {res_hi, res_lo} = prod;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: begin
        if (flush) state_nxt = IDLE;
        else if (count == CW'(WIDTH - 1)) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
`ifdef MULDIV_DIVZERO_TRAP_EN
      divZero <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
`ifdef MULDIV_DIVZERO_TRAP_EN
      divZero <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (accept) begin
            count  <= '0;
            acc_hi <= '0;
            is_div <= op[1];
            opnd   <= op[1] ? b_abs : a_abs;
            acc_lo <= op[1] ? a_abs : b_abs;
            neg_q  <= sgn && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
            neg_r  <= sgn && op[1] && srcA[WIDTH-1];
          end else if (mt_op) begin
            if (op[0]) lo <= srcA;
            else hi <= srcA;
          end
        end
        CALC: begin
          if (!flush) begin
            count <= count + CW'(1);
            if (is_div) begin
              acc_hi <= rem_nxt;
              acc_lo <= {acc_lo[WIDTH-2:0], q_bit};
            end else begin
              acc_hi <= madd[WIDTH:1];
              acc_lo <= {madd[0], acc_lo[WIDTH-1:1]};
            end
          end
        end
        FIX: begin
          if (!flush) begin
            done <= 1'b1;
`ifdef MULDIV_DIVZERO_TRAP_EN
            if (is_div && opnd == '0) begin
              divZero <= 1'b1;
            end else begin
              hi <= res_hi;
              lo <= res_lo;
            end
`else
            hi <= res_hi;
            lo <= res_lo;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, random ops vs model,
// and hand sequences for reset, flush, busy-start and MTHI/MTLO.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic         flush;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
`ifdef MULDIV_DIVZERO_TRAP_EN
  logic         divZero;
`endif

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .flush (flush),
    .srcA  (srcA),
    .srcB  (srcB),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
`ifdef MULDIV_DIVZERO_TRAP_EN
    ,
    .divZero (divZero)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;
  logic         m_dz;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Architectural reference: plain 64-bit arithmetic on HI/LO.
  task automatic model(input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m_dz = 1'b0;
    case (o)
      3'd0: begin
        p = sa * sb;
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd2, 3'd3: begin
        if (b == 0) begin
`ifdef MULDIV_DIVZERO_TRAP_EN
          m_dz = 1'b1;
`else
          m_hi = a;
          m_lo = (o == 3'd2 && a[W-1]) ? 32'h1 : 32'hFFFF_FFFF;
`endif
        end else if (o == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    op = o;
    srcA = a;
    srcB = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Issue a mult/div, optionally poke start while busy, check result timing.
  task automatic run_op(input string name, input logic [2:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input int intr);
    int k;
    issue(o, a, b);
    model(o, a, b);
    k = 1;
    check({name, "_busy"}, busy, 1);
    while (!done && k < 40) begin
      if (k == intr) begin
        op = 3'd3;
        srcA = 32'd1;
        srcB = 32'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      k++;
    end
    start = 1'b0;
    check({name, "_lat"}, k, 34);
    check({name, "_hi"}, hi, m_hi);
    check({name, "_lo"}, lo, m_lo);
    check({name, "_busylow"}, busy, 0);
`ifdef MULDIV_DIVZERO_TRAP_EN
    check({name, "_dz"}, divZero, m_dz);
`endif
  endtask

  initial begin
    int seen;
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;

    vecs[0] = '{3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
    vecs[4] = '{3'd3, 32'd100, 32'd7, 32'd2, 32'd14};
    vecs[5] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    vecs[6] = '{3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD};
    vecs[7] = '{3'd1, 32'h1234_5678, 32'h0, 32'h0, 32'h0};

    reset = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op = 3'd0;
    srcA = '0;
    srcB = '0;
    m_hi = '0;
    m_lo = '0;
    m_dz = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      seen = 1;
      while (!done && seen < 40) begin
        tick();
        seen++;
      end
      check($sformatf("vec%0d_lat", i), seen, 34);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
    end
    m_hi = vecs[7].hi;
    m_lo = vecs[7].lo;

    // start while busy must be ignored
    run_op("busy_start", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4);
    check("busy_start_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // reset in the middle of a MULT
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    repeat (8) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    check("midrst_busy", busy, 0);
    check("midrst_hilo", {hi, lo}, 64'h0);
    seen = 0;
    repeat (40) begin
      tick();
      if (done) seen++;
    end
    check("midrst_nodone", seen, 0);
    run_op("after_rst", 3'd0, 32'hFFFF_FFFD, 32'd5, 0);

    // MTHI / MTLO back to back
    issue(3'd4, 32'h1234_5678, 32'h0);
    model(3'd4, 32'h1234_5678, 32'h0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", busy, 0);
    issue(3'd5, 32'h9ABC_DEF0, 32'h0);
    model(3'd5, 32'h9ABC_DEF0, 32'h0);
    check("mtlo_lo", lo, 32'h9ABC_DEF0);
    check("mtlo_busy", busy, 0);
    check("mt_done", done, 0);

    // flush during a DIVU
    issue(3'd3, 32'd1000, 32'd3);
    repeat (18) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", busy, 0);
    seen = 0;
    repeat (40) begin
      tick();
      if (done) seen++;
    end
    check("flush_nodone", seen, 0);
    check("flush_hilo", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0});

    // flush with start in IDLE drops the start; reserved op ignored
    flush = 1'b1;
    issue(3'd4, 32'hDEAD_BEEF, 32'h0);
    flush = 1'b0;
    check("flush_start_hi", hi, 32'h1234_5678);
    flush = 1'b1;
    issue(3'd0, 32'd3, 32'd3);
    flush = 1'b0;
    check("flush_start_busy", busy, 0);
    issue(3'd6, 32'hDEAD_BEEF, 32'h1);
    check("rsvd_busy", busy, 0);
    check("rsvd_hilo", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0});

    // divide by zero
    run_op("divu0", 3'd3, 32'h64, 32'h0, 0);
    run_op("divneg0", 3'd2, 32'hFFFF_FFF9, 32'h0, 0);
    run_op("divpos0", 3'd2, 32'd7, 32'h0, 0);

    // random back-to-back ops against the model
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 9) == 0) rb = '0;
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
      run_op($sformatf("rnd%0d", i), ro, ra, rb, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
